imem_bridge: RTL

//  Memory-side bridge under the fetch controller's mem_req port (fed by the uncompressed icache refill path).

---
 rtl/imem_bridge_pkg.sv | 17 +
 rtl/imem_bridge.sv | 109 ++++++++++
 2 files changed

// File: rtl/imem_bridge_pkg.sv
// Shared types and constants for the instruction-memory bridge.
package imem_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  localparam logic [31:0]  ERR_DATA_DEF = 32'h0000_0013;
  localparam int unsigned  CNT_W        = 16;
  localparam int unsigned  WCNT_W       = 8;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

endpackage

// File: rtl/imem_bridge.sv
// Bridges the valid / one-cycle-ready fetch request onto a 1-cycle-latency SRAM,
// with wait states, range checking and a saturating completion counter.
module imem_bridge
  import imem_bridge_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic [31:0]       req_rdata,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_rdata,
  output logic              busy,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  req_count
);

  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WAIT_STATES - 1);

  state_e             r_state;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_rdata;
  logic               r_ready;
  logic               r_err;
  logic [CNT_W-1:0]   r_count;

  logic w_oor;
  logic w_unused_lsb;

  assign w_oor        = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
  assign w_unused_lsb = ^req_addr[1:0];

  // Request sequencer; req_ready is set on entry to RESP so it is high only in RESP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
      r_addr  <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr <= req_addr[ADDR_W+1:2];
            if (w_oor) begin
              r_rdata <= ERR_DATA;
              r_err   <= 1'b1;
              r_ready <= 1'b1;
              r_state <= ST_RESP;
            end else if (WAIT_STATES != 0) begin
              r_wcnt  <= WCNT_LOAD;
              r_state <= ST_WAIT;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_WAIT: begin
          if (!req_valid) begin
            r_state <= ST_IDLE;
          end else if (r_wcnt == '0) begin
            r_state <= ST_ISSUE;
          end else begin
            r_wcnt <= r_wcnt - WCNT_W'(1);
          end
        end
        ST_ISSUE: begin
          r_state <= req_valid ? ST_CAPTURE : ST_IDLE;
        end
        ST_CAPTURE: begin
          // A dropped request discards the SRAM word that arrives now.
          if (!req_valid) begin
            r_state <= ST_IDLE;
          end else begin
            r_rdata <= sram_rdata;
            r_ready <= 1'b1;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (r_count != CNT_MAX) r_count <= r_count + CNT_W'(1);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sram_en    = (r_state == ST_ISSUE);
  assign sram_addr  = r_addr;
  assign busy       = (r_state != ST_IDLE);
  assign req_ready  = r_ready;
  assign req_rdata  = r_rdata;
  assign err_sticky = r_err;
  assign req_count  = r_count;

endmodule
